// File: rtl/multi_cycle_controller.sv
// Control FSM for a multi-cycle MIPS datapath: sequences PC/IR/MDR/A/B/ALUOut,
// flags unsupported instructions and counts retired instructions.
module multi_cycle_controller #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic             AluZero,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             SZEn,
   output logic [3:0]       AluOP,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_retired
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_REX    = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_IEX    = 4'd8;
   localparam logic [3:0] S_IWB    = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_NOR  = 4'd6;
   localparam logic [3:0] ALU_XOR  = 4'd7;
   localparam logic [3:0] ALU_LUI  = 4'd8;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   logic [3:0] next_state;
   logic [3:0] r_aluop_c;
   logic       r_legal_c;
   logic [3:0] i_aluop_c;
   logic       i_sext_c;
   logic       is_itype_c;
   logic       is_mem_c;
   logic       is_branch_c;
   logic       decode_legal_c;
   logic       retire_c;

   // R-format function decode
   always_comb begin
      r_aluop_c = ALU_ADD;
      r_legal_c = 1'b1;
      case (func)
         6'b100000, 6'b100001: r_aluop_c = ALU_ADD;
         6'b100010, 6'b100011: r_aluop_c = ALU_SUB;
         6'b100100:            r_aluop_c = ALU_AND;
         6'b100101:            r_aluop_c = ALU_OR;
         6'b100110:            r_aluop_c = ALU_XOR;
         6'b100111:            r_aluop_c = ALU_NOR;
         6'b101010:            r_aluop_c = ALU_SLT;
         6'b101011:            r_aluop_c = ALU_SLTU;
         default:              r_legal_c = 1'b0;
      endcase
   end

   // I-format ALU decode; logical ops and lui zero-extend
   always_comb begin
      i_aluop_c  = ALU_ADD;
      i_sext_c   = 1'b1;
      is_itype_c = 1'b1;
      case (op)
         OP_ADDI, OP_ADDIU: i_aluop_c = ALU_ADD;
         OP_SLTI:           i_aluop_c = ALU_SLT;
         OP_SLTIU: begin i_aluop_c = ALU_SLTU; i_sext_c = 1'b0; end
         OP_ANDI:  begin i_aluop_c = ALU_AND;  i_sext_c = 1'b0; end
         OP_ORI:   begin i_aluop_c = ALU_OR;   i_sext_c = 1'b0; end
         OP_XORI:  begin i_aluop_c = ALU_XOR;  i_sext_c = 1'b0; end
         OP_LUI:   begin i_aluop_c = ALU_LUI;  i_sext_c = 1'b0; end
         default:  is_itype_c = 1'b0;
      endcase
   end

   always_comb begin
      is_mem_c       = (op == OP_LW) || (op == OP_SW);
      is_branch_c    = (op == OP_BEQ) || (op == OP_BNE);
      decode_legal_c = is_mem_c || is_branch_c || is_itype_c || ((op == OP_R) && r_legal_c);
      retire_c       = (state == S_MEMWB) || (state == S_MEMWR) || (state == S_RWB) ||
                       (state == S_IWB) || (state == S_BRANCH);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH: next_state = S_DECODE;
         S_DECODE: begin
            if (is_mem_c)                     next_state = S_MEMADR;
            else if (op == OP_R && r_legal_c) next_state = S_REX;
            else if (is_itype_c)              next_state = S_IEX;
            else if (is_branch_c)             next_state = S_BRANCH;
            else                              next_state = S_FETCH;
         end
         S_MEMADR: next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  next_state = S_MEMWB;
         S_REX:    next_state = S_RWB;
         S_IEX:    next_state = S_IWB;
         default:  next_state = S_FETCH;
      endcase
   end

   // Output decode; reset masks every write enable so an aborted instruction commits nothing
   always_comb begin
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      SZEn     = 1'b0;
      AluOP    = ALU_ADD;
      illegal  = 1'b0;
      case (state)
         S_FETCH: begin
            IRWrite = 1'b1;
            ALUSrcB = 2'b01;
            PCWrite = 1'b1;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            SZEn    = 1'b1;
            illegal = ~decode_legal_c;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            SZEn    = 1'b1;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_REX: begin
            ALUSrcA = 1'b1;
            AluOP   = r_aluop_c;
         end
         S_RWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_IEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            SZEn    = i_sext_c;
            AluOP   = i_aluop_c;
         end
         S_IWB: RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            AluOP   = ALU_SUB;
            PCSrc   = 1'b1;
            PCWrite = (op == OP_BNE) ? ~AluZero : AluZero;
         end
         default: ;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         illegal  = 1'b0;
      end
   end

   // Retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset)         instr_retired <= '0;
      else if (retire_c) instr_retired <= instr_retired + CNT_W'(1);
   end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed-vector bench for multi_cycle_controller; a 4-bit counter makes wrap reachable.
module tb_multi_cycle_controller;

   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             reset;
   logic [5:0]       op;
   logic [5:0]       func;
   logic             AluZero;
   logic             PCWrite;
   logic             PCSrc;
   logic             IorD;
   logic             MemWrite;
   logic             IRWrite;
   logic             RegDst;
   logic             MemtoReg;
   logic             RegWrite;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic             SZEn;
   logic [3:0]       AluOP;
   logic             illegal;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_retired;

   int               errors = 0;
   int               checks = 0;
   logic [CNT_W-1:0] exp_ret = '0;

   multi_cycle_controller #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .op(op), .func(func), .AluZero(AluZero),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .SZEn(SZEn), .AluOP(AluOP),
      .illegal(illegal), .state(state), .instr_retired(instr_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle and stay clear of the edge
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      reset = 1'b1; op = 6'd0; func = 6'd0; AluZero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({PCWrite, IRWrite, RegWrite, MemWrite, illegal} !== 5'b0) begin
            errors++;
            $display("FAIL reset_enables[%0d]: got %b want 00000", i,
                     {PCWrite, IRWrite, RegWrite, MemWrite, illegal});
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({state, PCWrite, IRWrite, ALUSrcB} !== {4'd0, 1'b1, 1'b1, 2'b01}) begin
         errors++;
         $display("FAIL reset_fetch: state=%0d PCWrite=%b IRWrite=%b ALUSrcB=%b want 0 1 1 01",
                  state, PCWrite, IRWrite, ALUSrcB);
      end
      checks++;
      if (instr_retired !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d want 0", instr_retired);
      end
      exp_ret = '0;
   endtask

   task automatic test_lw;
      logic [3:0] seq [5];
      seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      op = 6'b100011; func = 6'd0;
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         checks++;
         if (state !== seq[i]) begin
            errors++;
            $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i]);
         end
         checks++;
         if ({RegWrite, MemtoReg} !== ((i == 4) ? 2'b11 : 2'b00)) begin
            errors++;
            $display("FAIL lw_wb[%0d]: RegWrite,MemtoReg got %b", i, {RegWrite, MemtoReg});
         end
      end
      tick();
      exp_ret = exp_ret + 4'd1;
      checks++;
      if ({state, instr_retired} !== {4'd0, exp_ret}) begin
         errors++;
         $display("FAIL lw_retire: state=%0d count=%0d want 0 %0d", state, instr_retired, exp_ret);
      end
   endtask

   task automatic test_sw;
      logic [3:0] seq [4];
      seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      op = 6'b101011;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         checks++;
         if (state !== seq[i]) begin
            errors++;
            $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, seq[i]);
         end
         checks++;
         if ({MemWrite, RegWrite} !== ((i == 3) ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL sw_strobes[%0d]: MemWrite,RegWrite got %b", i, {MemWrite, RegWrite});
         end
      end
      checks++;
      if (IorD !== 1'b1) begin
         errors++;
         $display("FAIL sw_iord: got %b want 1", IorD);
      end
      tick();
      exp_ret = exp_ret + 4'd1;
      checks++;
      if ({state, instr_retired} !== {4'd0, exp_ret}) begin
         errors++;
         $display("FAIL sw_retire: state=%0d count=%0d want 0 %0d", state, instr_retired, exp_ret);
      end
   endtask

   task automatic test_rtype;
      logic [5:0] funcs [2];
      logic [3:0] ops   [2];
      funcs = '{6'b100111, 6'b101011};
      ops   = '{4'd6, 4'd3};
      for (int k = 0; k < 2; k++) begin
         op = 6'b000000; func = funcs[k];
         #1;
         tick();
         checks++;
         if ({state, illegal} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL r_decode[%0d]: state=%0d illegal=%b want 1 0", k, state, illegal);
         end
         tick();
         checks++;
         if ({state, AluOP, ALUSrcA, ALUSrcB} !== {4'd6, ops[k], 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL r_rex[%0d]: state=%0d AluOP=%0d A=%b B=%b want 6 %0d 1 00",
                     k, state, AluOP, ALUSrcA, ALUSrcB, ops[k]);
         end
         tick();
         checks++;
         if ({state, RegDst, RegWrite, MemtoReg} !== {4'd7, 3'b110}) begin
            errors++;
            $display("FAIL r_rwb[%0d]: state=%0d RegDst,RegWrite,MemtoReg=%b want 7 110",
                     k, state, {RegDst, RegWrite, MemtoReg});
         end
         tick();
         exp_ret = exp_ret + 4'd1;
         checks++;
         if ({state, instr_retired} !== {4'd0, exp_ret}) begin
            errors++;
            $display("FAIL r_retire[%0d]: state=%0d count=%0d want 0 %0d", k, state, instr_retired, exp_ret);
         end
      end
      // Unsupported func, then an unsupported opcode (j)
      for (int k = 0; k < 2; k++) begin
         op = (k == 0) ? 6'b000000 : 6'b000010; func = 6'b000000;
         #1;
         tick();
         checks++;
         if ({state, illegal} !== {4'd1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_decode[%0d]: state=%0d illegal=%b want 1 1", k, state, illegal);
         end
         tick();
         checks++;
         if ({state, illegal, instr_retired} !== {4'd0, 1'b0, exp_ret}) begin
            errors++;
            $display("FAIL illegal_return[%0d]: state=%0d illegal=%b count=%0d want 0 0 %0d",
                     k, state, illegal, instr_retired, exp_ret);
         end
      end
   endtask

   task automatic test_itype;
      logic [5:0] opc  [3];
      logic       szen [3];
      logic [3:0] alu  [3];
      opc  = '{6'b001100, 6'b001010, 6'b001111};
      szen = '{1'b0, 1'b1, 1'b0};
      alu  = '{4'd4, 4'd2, 4'd8};
      for (int k = 0; k < 3; k++) begin
         op = opc[k]; func = 6'b100000;
         #1;
         tick();
         tick();
         checks++;
         if ({state, SZEn, AluOP, ALUSrcA, ALUSrcB} !== {4'd8, szen[k], alu[k], 1'b1, 2'b10}) begin
            errors++;
            $display("FAIL i_iex[%0d]: state=%0d SZEn=%b AluOP=%0d A=%b B=%b want 8 %b %0d 1 10",
                     k, state, SZEn, AluOP, ALUSrcA, ALUSrcB, szen[k], alu[k]);
         end
         tick();
         checks++;
         if ({state, RegDst, RegWrite, MemtoReg} !== {4'd9, 3'b010}) begin
            errors++;
            $display("FAIL i_iwb[%0d]: state=%0d RegDst,RegWrite,MemtoReg=%b want 9 010",
                     k, state, {RegDst, RegWrite, MemtoReg});
         end
         tick();
         exp_ret = exp_ret + 4'd1;
         checks++;
         if ({state, instr_retired} !== {4'd0, exp_ret}) begin
            errors++;
            $display("FAIL i_retire[%0d]: state=%0d count=%0d want 0 %0d", k, state, instr_retired, exp_ret);
         end
      end
   endtask

   task automatic test_branch;
      logic [5:0] opc [4];
      logic       az  [4];
      logic       pcw [4];
      opc = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
      az  = '{1'b1, 1'b0, 1'b0, 1'b1};
      pcw = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) begin
         op = opc[k]; AluZero = az[k];
         #1;
         tick();
         checks++;
         if ({state, ALUSrcA, ALUSrcB, SZEn} !== {4'd1, 1'b0, 2'b11, 1'b1}) begin
            errors++;
            $display("FAIL br_decode[%0d]: state=%0d A=%b B=%b SZEn=%b want 1 0 11 1",
                     k, state, ALUSrcA, ALUSrcB, SZEn);
         end
         tick();
         checks++;
         if ({state, PCWrite, PCSrc, AluOP} !== {4'd10, pcw[k], 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL br_branch[%0d]: state=%0d PCWrite=%b PCSrc=%b AluOP=%0d want 10 %b 1 1",
                     k, state, PCWrite, PCSrc, AluOP, pcw[k]);
         end
         tick();
         exp_ret = exp_ret + 4'd1;
         checks++;
         if ({state, instr_retired} !== {4'd0, exp_ret}) begin
            errors++;
            $display("FAIL br_retire[%0d]: state=%0d count=%0d want 0 %0d", k, state, instr_retired, exp_ret);
         end
      end
      AluZero = 1'b0;
   endtask

   task automatic test_reset_abort;
      op = 6'b101011;
      #1;
      tick();
      tick();
      tick();
      checks++;
      if ({state, MemWrite} !== {4'd5, 1'b1}) begin
         errors++;
         $display("FAIL abort_pre: state=%0d MemWrite=%b want 5 1", state, MemWrite);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({MemWrite, RegWrite, PCWrite, IRWrite} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_mask: MemWrite,RegWrite,PCWrite,IRWrite=%b want 0000",
                  {MemWrite, RegWrite, PCWrite, IRWrite});
      end
      tick();
      reset = 1'b0;
      #1;
      exp_ret = '0;
      checks++;
      if ({state, instr_retired} !== {4'd0, 4'd0}) begin
         errors++;
         $display("FAIL abort_after: state=%0d count=%0d want 0 0", state, instr_retired);
      end
   endtask

   task automatic test_wrap;
      op = 6'b000100; AluZero = 1'b0;
      #1;
      for (int n = 1; n <= 16; n++) begin
         tick();
         tick();
         tick();
         exp_ret = exp_ret + 4'd1;
         checks++;
         if (instr_retired !== exp_ret) begin
            errors++;
            $display("FAIL wrap_count[%0d]: got %0d want %0d", n, instr_retired, exp_ret);
         end
      end
      checks++;
      if (instr_retired !== 4'd0) begin
         errors++;
         $display("FAIL wrap_zero: got %0d want 0", instr_retired);
      end
   endtask

   initial begin
      reset = 1'b1; op = 6'd0; func = 6'd0; AluZero = 1'b0;
      test_reset();
      test_lw();
      test_sw();
      test_rtype();
      test_itype();
      test_branch();
      test_reset_abort();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS datapath. The datapath shares one memory for instructions and data, and one ALU that also computes PC+4 and the branch target.
- Supports the same instruction set as the single-cycle core. R format: add(u), sub(u), and, or, xor, nor, slt, sltu. I format: beq, bne, lw, sw, addi(u), slti, sltiu, andi, ori, xori, lui.
- Sits beside the datapath's PC, IR, MDR, A/B and ALUOut registers and drives all of their enables and mux selects.
- Also reports illegal instructions and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  6  IR[31:26], valid from DECODE onward
func  in  6  IR[5:0]
AluZero  in  1  ALU zero flag, valid in the same cycle as the ALU result
PCWrite  out  1  PC register load enable
PCSrc  out  1  PC next-value select: 0 = ALU result, 1 = ALUOut register
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load enable (MDR loads every cycle)
RegDst  out  1  write-register select: 1 = rd, 0 = rt
MemtoReg  out  1  register write-data select: 1 = MDR, 0 = ALUOut
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register
ALUSrcB  out  2  ALU B select: 00 = B reg, 01 = constant 4, 10 = Imm32, 11 = Imm32<<2
SZEn  out  1  immediate extension: 1 = sign extend, 0 = zero extend
AluOP  out  4  ALU operation code (see Behaviour)
illegal  out  1  one-cycle pulse, asserted in DECODE when op/func is unsupported
state  out  4  current state encoding (debug)
instr_retired  out  CNT_W  retired-instruction count

Behaviour:
- AluOP codes: ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, OR=5, NOR=6, XOR=7, LUI=8.
- Unless a state lists a signal, it is 0.
- State encodings and outputs:
  - FETCH=0: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, AluOP=ADD, PCSrc=0, PCWrite=1. Next state: DECODE.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, SZEn=1, AluOP=ADD (branch target goes to ALUOut). Next state by op:
    - lw/sw -> MEMADR
    - op=0 with a legal func -> REX
    - addi/addiu/slti/sltiu/andi/ori/xori/lui -> IEX
    - beq/bne -> BRANCH
    - anything else (including op=0 with an unsupported func) -> FETCH with illegal=1 for this cycle.
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, SZEn=1, AluOP=ADD. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD=3: IorD=1. Next: MEMWB.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR=5: IorD=1, MemWrite=1. Next: FETCH.
  - REX=6: ALUSrcA=1, ALUSrcB=00. AluOP from func:
    - 100000/100001 -> ADD
    - 100010/100011 -> SUB
    - 100100 -> AND
    - 100101 -> OR
    - 100110 -> XOR
    - 100111 -> NOR
    - 101010 -> SLT
    - 101011 -> SLTU
    - Next: RWB.
  - RWB=7: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - IEX=8: ALUSrcA=1, ALUSrcB=10.
    - SZEn=1 for addi/addiu/slti; SZEn=0 for sltiu/andi/ori/xori/lui.
    - AluOP by op: addi/addiu -> ADD, slti -> SLT, sltiu -> SLTU, andi -> AND, ori -> OR, xori -> XOR, lui -> LUI.
    - Next: IWB.
  - IWB=9: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH=10: ALUSrcA=1, ALUSrcB=00, AluOP=SUB, PCSrc=1.
    - PCWrite = AluZero for beq, ~AluZero for bne. This is the only Mealy output.
    - Next: FETCH.
- Latency in cycles including FETCH: lw 5; sw, R-type and I-type 4; beq/bne 3; illegal 2.
- op/func are sampled in every state after FETCH; IR is stable because IRWrite=1 only in FETCH.
- Encodings 11-15 are unreachable; if entered, go to FETCH with all write enables 0.
- Reset (synchronous), while reset=1:
  - state is forced to FETCH on the next edge.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0, and illegal is forced to 0.
  - instr_retired is cleared to 0.
  - Reset asserted mid-instruction aborts it; no pending write is issued.
  - First FETCH outputs appear in the cycle after reset deasserts.
- instr_retired increments by 1 on each clock edge leaving MEMWB, MEMWR, RWB, IWB or BRANCH (taken or not).
  - It does not count illegal instructions.
  - It wraps modulo 2^CNT_W.
  - The increment and reset are not simultaneous: reset has priority.

Test Plan:
- Reset for 2 cycles, then release -> state=0 in the first cycle after release, PCWrite=1, IRWrite=1, ALUSrcB=01, instr_retired=0; during reset all write enables are 0.
- lw (op=100011) -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in state 4; instr_retired=1 after 5 cycles. Then sw (op=101011) -> 0,1,2,5, MemWrite=1 only in state 5, RegWrite never 1.
- R-type op=0 with func=100111 -> AluOP=6 in REX, RegDst=1 with RegWrite=1 in RWB. func=101011 -> AluOP=3. func=000000 -> illegal=1 in DECODE, back to FETCH, instr_retired unchanged.
- andi (op=001100) -> SZEn=0, AluOP=4, ALUSrcB=10 in IEX. slti (001010) -> SZEn=1, AluOP=2. lui (001111) -> AluOP=8. Each writes through IWB with RegDst=0.
- beq with AluZero=1 -> PCWrite=1, PCSrc=1 in BRANCH; with AluZero=0 -> PCWrite=0. bne with AluZero=0 -> PCWrite=1. All take 3 cycles, and instr_retired increments in every case.
- Assert reset in MEMWR cycle -> MemWrite=0 in that cycle, state=0 next cycle, instr_retired=0. Separately, preload the counter near 2^CNT_W-1 (CNT_W=4, 16 retirements) -> it wraps to 0.
